// File: rtl/bht_predictor.sv
// Branch history table: 2-bit saturating counters predicting decode-stage branches,
// trained by execute-stage resolves. Define BHT_GSHARE_EN for gshare (PC ^ GHR) indexing.
module bht_predictor #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             predict_taken,
  input  logic             resolve_valid,
  input  logic [31:0]      resolve_pc,
  input  logic             resolve_taken,
  input  logic             resolve_predicted,
  input  logic [31:0]      resolve_target,
  input  logic [31:0]      resolve_fallthru,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] mispredict_count
`ifdef BHT_GSHARE_EN
  ,
  output logic [IDX_W-1:0] lookup_hist,
  input  logic [IDX_W-1:0] resolve_hist
`endif
);

  localparam int TABLE_SIZE = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  logic [1:0]       bhtTable [TABLE_SIZE];
  logic [IDX_W-1:0] lookupIdx;
  logic [IDX_W-1:0] resolveIdx;
  logic             isMispredict;

  function automatic logic [1:0] satInc(input logic [1:0] cnt);
    return (cnt == 2'b11) ? cnt : cnt + 2'b01;
  endfunction

  function automatic logic [1:0] satDec(input logic [1:0] cnt);
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  logic             unusedBits;

  assign lookupIdx   = lookup_pc[IDX_W-1:0] ^ ghr;
  assign resolveIdx  = resolve_pc[IDX_W-1:0] ^ resolve_hist;
  assign lookup_hist = ghr;
  assign unusedBits  = ^{lookup_pc[31:IDX_W], resolve_pc[31:IDX_W], resolve_hist[IDX_W-1]};

  // History is rebuilt from the resolved branch's own history, so a
  // mispredicted path never pollutes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ghr <= '0;
    end else if (resolve_valid) begin
      ghr <= {resolve_hist[IDX_W-2:0], resolve_taken};
    end
  end
`else
  logic unusedBits;

  assign lookupIdx  = lookup_pc[IDX_W-1:0];
  assign resolveIdx = resolve_pc[IDX_W-1:0];
  assign unusedBits = ^{lookup_pc[31:IDX_W], resolve_pc[31:IDX_W]};
`endif

  // Reads the table before this cycle's update lands: no forwarding.
  assign predict_taken = lookup_valid & bhtTable[lookupIdx][1];
  assign isMispredict  = resolve_valid & (resolve_taken != resolve_predicted);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        bhtTable[i] <= 2'b01;
      end
    end else if (resolve_valid) begin
      bhtTable[resolveIdx] <= resolve_taken ? satInc(bhtTable[resolveIdx])
                                            : satDec(bhtTable[resolveIdx]);
    end
  end

  // Resolve -> flush pulse boundary: outputs are one cycle behind the resolve.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= isMispredict;
      if (isMispredict) begin
        redirect_pc <= resolve_taken ? resolve_target : resolve_fallthru;
        if (mispredict_count != COUNT_MAX) begin
          mispredict_count <= mispredict_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
